// File: rtl/timer_irq_dev_pkg.sv
// Shared definitions for the countdown timer: register map, CTRL layout, modes,
// FSM encoding and the CP0 hardware interrupt line the timer drives.
package timer_irq_dev_pkg;

    // Word offsets (bus address bits [3:2])
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] AddrPresc  = 2'd3;

    // CTRL bit positions
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;
    localparam int unsigned CtrlPendBit = 4;

    // MODE encodings; the reserved 1x codes behave as one-shot
    localparam logic [1:0] ModeOneShot = 2'b00;
    localparam logic [1:0] ModeReload  = 2'b01;

    // CP0 HWInt line fed by this timer
    localparam int unsigned HwIntTimer = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2
    } state_e;

    // Assemble the CTRL read value; undefined bits read as zero
    function automatic logic [31:0] pack_ctrl(input logic en, input logic [1:0] mode,
                                              input logic im, input logic pend);
        pack_ctrl = {27'b0, pend, im, mode, en};
    endfunction

endpackage

// File: rtl/timer_irq_dev_prescaler.sv
// Prescale counter: raises tick every PRESC+1 clocks while not held clear.
module timer_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    localparam logic [PRESC_W-1:0] CtrOne = PRESC_W'(1);

    logic [PRESC_W-1:0] ctr_q, ctr_d;

    assign tick_o = (ctr_q == presc_i);

    // Wrap on tick; a shrunken PRESC below ctr lets ctr run on to natural 2^PRESC_W wrap
    always_comb begin
        ctr_d = ctr_q + CtrOne;
        if (clr_i || tick_o) begin
            ctr_d = '0;
        end
    end

    // Prescale counter state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with one-shot/auto-reload modes and a
// level interrupt (PEND & IM, registered) for CP0 HWInt[2].
module timer_irq_dev
    import timer_irq_dev_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic [1:0]  addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             state_q;
    logic               en_q, im_q, pend_q, irq_q;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   preset_q, count_q;
    logic [PRESC_W-1:0] presc_q;

    logic ctrl_wr, preset_wr, presc_wr, wr_en, tick;

    assign ctrl_wr   = cs_i && we_i && (addr_i == AddrCtrl);
    assign preset_wr = cs_i && we_i && (addr_i == AddrPreset);
    assign presc_wr  = cs_i && we_i && (addr_i == AddrPresc);
    assign wr_en     = wdata_i[CtrlEnBit];

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (state_q != StCnt),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    // Registers, FSM and COUNT datapath; later assignments take priority
    // (terminal-count PEND set beats a same-cycle W1C, one-shot EN clear beats the write)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            mode_q   <= ModeOneShot;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
        end else begin
            irq_q <= pend_q & im_q;
            if (ctrl_wr) begin
                en_q   <= wr_en;
                mode_q <= wdata_i[CtrlModeMsb:CtrlModeLsb];
                im_q   <= wdata_i[CtrlImBit];
                if (wdata_i[CtrlPendBit]) begin
                    pend_q <= 1'b0;
                end
            end
            if (preset_wr) begin
                preset_q <= wdata_i[CNT_W-1:0];
            end
            if (presc_wr) begin
                presc_q <= wdata_i[PRESC_W-1:0];
            end
            unique case (state_q)
                StIdle: begin
                    if (ctrl_wr && wr_en) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (ctrl_wr && !wr_en) begin
                        state_q <= StIdle;
                    end else begin
                        count_q <= preset_q;
                        state_q <= StCnt;
                    end
                end
                StCnt: begin
                    if (ctrl_wr && !wr_en) begin
                        state_q <= StIdle;
                    end else if (tick) begin
                        if (count_q != '0) begin
                            count_q <= count_q - CntOne;
                        end else begin
                            pend_q <= 1'b1;
                            if (mode_q == ModeReload) begin
                                state_q <= StLoad;
                            end else begin
                                en_q    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational read mux; deselected bus reads zero
    always_comb begin
        rdata_o = '0;
        if (cs_i) begin
            unique case (addr_i)
                AddrCtrl:   rdata_o = pack_ctrl(en_q, mode_q, im_q, pend_q);
                AddrPreset: rdata_o = 32'(preset_q);
                AddrCount:  rdata_o = 32'(count_q);
                AddrPresc:  rdata_o = 32'(presc_q);
                default:    rdata_o = '0;
            endcase
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_timer_irq_dev.sv
// Self-checking bench for timer_irq_dev: register table plus scheduled scoreboard checks.
module tb_timer_irq_dev;

    logic        clk = 1'b0;
    logic        rst, cs, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    timer_irq_dev #(
        .CNT_W   (32),
        .PRESC_W (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .cs_i    (cs),
        .addr_i  (addr),
        .we_i    (we),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    typedef struct {
        string       name;
        int          at;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    typedef struct {
        logic        wcs;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rcs;
        logic [31:0] exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[8];

    // auto-reload reference state
    int   m_edge;
    int   m_e0;
    logic m_pend;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] r,
                          input logic i);
        cs = 1'b1;
        we = 1'b0;
        addr = a;
        #1;
        cmp(name, rdata, r);
        cmp({name, " irq"}, {31'b0, irq}, {31'b0, i});
        cs = 1'b0;
    endtask

    task automatic push(input string name, input int at, input logic [1:0] a,
                        input logic [31:0] r, input logic i);
        exp_t e;
        e.name = name;
        e.at = at;
        e.addr = a;
        e.rdata = r;
        e.irq = i;
        sb_q.push_back(e);
    endtask

    // Pop each expectation when its edge arrives and compare at the following negedge
    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            int guard;
            e = sb_q.pop_front();
            guard = 0;
            while (edge_cnt < e.at && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (edge_cnt != e.at) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: sampled at edge %0d expected edge %0d", e.name, edge_cnt,
                         e.at);
            end else begin
                rd_chk(e.name, e.addr, e.rdata, e.irq);
            end
        end
    endtask

    // Drive a write now; returns the index of the edge that takes it
    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
        cs = 1'b1;
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
        e = edge_cnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs = 1'b0;
        we = 1'b0;
        addr = 2'd0;
        wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Auto-reload model, PRESET=2/PRESC=0: PEND sets every 4th edge after the enabling write
    task automatic model_adv(input int upto, input int clr_edge, input int from);
        logic m_irq;
        while (m_edge < upto) begin
            m_edge++;
            m_irq = m_pend;
            if (m_edge == clr_edge) m_pend = 1'b0;
            if (((m_edge - m_e0) % 4) == 0) m_pend = 1'b1;
            if (m_edge >= from)
                push("t3 reload ctrl", m_edge, 2'd0, 32'h0B | {27'b0, m_pend, 4'b0}, m_irq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w, dummy;

        tbl[0] = '{1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b1, 2'd3, 32'h000001FF, 1'b1, 32'h000000FF};
        tbl[2] = '{1'b1, 1'b1, 2'd2, 32'h00001234, 1'b1, 32'h00000000};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 32'h00000018, 1'b1, 32'h00000008};
        tbl[4] = '{1'b1, 1'b1, 2'd0, 32'hFFFFFFE6, 1'b1, 32'h00000006};
        tbl[5] = '{1'b0, 1'b0, 2'd1, 32'h00000000, 1'b0, 32'h00000000};
        tbl[6] = '{1'b0, 1'b0, 2'd1, 32'h00000000, 1'b1, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 1'b1, 2'd1, 32'h00000055, 1'b1, 32'hDEADBEEF};

        // Reset values visible while reset is held
        rst = 1'b1;
        cs = 1'b0;
        we = 1'b0;
        addr = 2'd0;
        wdata = '0;
        @(negedge clk);
        for (int a = 0; a < 4; a++) rd_chk("reset value", 2'(a), 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Register access table (timer stays idle throughout)
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].we) begin
                cs = tbl[i].wcs;
                we = 1'b1;
                addr = tbl[i].addr;
                wdata = tbl[i].wdata;
                @(posedge clk);
                #1;
                cs = 1'b0;
                we = 1'b0;
            end
            @(negedge clk);
            cs = tbl[i].rcs;
            addr = tbl[i].addr;
            #1;
            cmp($sformatf("table %0d rdata", i), rdata, tbl[i].exp);
            cmp($sformatf("table %0d irq", i), {31'b0, irq}, 32'h0);
            cs = 1'b0;
        end

        // One-shot, PRESET=3, PRESC=0: irq at E6
        do_reset();
        wr(2'd1, 32'd3, dummy);
        wr(2'd3, 32'd0, dummy);
        wr(2'd0, 32'h09, e0);
        push("t2 count E1", e0 + 1, 2'd2, 32'd3, 1'b0);
        push("t2 count E4", e0 + 4, 2'd2, 32'd0, 1'b0);
        push("t2 ctrl E5", e0 + 5, 2'd0, 32'h18, 1'b0);
        push("t2 ctrl E6", e0 + 6, 2'd0, 32'h18, 1'b1);
        drain();

        // Auto-reload, PRESET=2: PEND every 4 clocks, W1C each period
        do_reset();
        wr(2'd1, 32'd2, dummy);
        wr(2'd3, 32'd0, dummy);
        wr(2'd0, 32'h0B, e0);
        m_e0 = e0;
        m_edge = e0;
        m_pend = 1'b0;
        model_adv(e0 + 5, -1, e0 + 1);
        drain();
        for (int k = 0; k < 3; k++) begin
            wr(2'd0, 32'h1B, w);
            model_adv(w + 4, w, w);
            drain();
        end

        // One-shot, PRESET=1, PRESC=2: a tick every 3 clocks; PEND at E7, irq at E8
        do_reset();
        wr(2'd1, 32'd1, dummy);
        wr(2'd3, 32'd2, dummy);
        wr(2'd0, 32'h09, e0);
        push("t4 count E1", e0 + 1, 2'd2, 32'd1, 1'b0);
        push("t4 count E3", e0 + 3, 2'd2, 32'd1, 1'b0);
        push("t4 count E4", e0 + 4, 2'd2, 32'd0, 1'b0);
        push("t4 ctrl E6", e0 + 6, 2'd0, 32'h09, 1'b0);
        push("t4 ctrl E7", e0 + 7, 2'd0, 32'h18, 1'b0);
        push("t4 ctrl E8", e0 + 8, 2'd0, 32'h18, 1'b1);
        drain();

        // W1C landing on the terminal-count edge: set wins
        do_reset();
        wr(2'd1, 32'd3, dummy);
        wr(2'd3, 32'd0, dummy);
        wr(2'd0, 32'h09, e0);
        push("t5 count E4", e0 + 4, 2'd2, 32'd0, 1'b0);
        drain();
        wr(2'd0, 32'h19, w);
        cmp("t5 w1c edge", 32'(w), 32'(e0 + 5));
        push("t5 ctrl at tc", w, 2'd0, 32'h18, 1'b0);
        push("t5 ctrl tc+1", w + 1, 2'd0, 32'h18, 1'b1);
        push("t5 ctrl tc+2", w + 2, 2'd0, 32'h18, 1'b1);
        drain();

        // IM=0 masks irq, PEND persists; unmask raises irq one cycle later
        do_reset();
        wr(2'd1, 32'd0, dummy);
        wr(2'd3, 32'd0, dummy);
        wr(2'd0, 32'h01, e0);
        push("t6 masked E2", e0 + 2, 2'd0, 32'h10, 1'b0);
        push("t6 masked E4", e0 + 4, 2'd0, 32'h10, 1'b0);
        drain();
        wr(2'd0, 32'h08, w);
        push("t6 unmask W", w, 2'd0, 32'h18, 1'b0);
        push("t6 unmask W+1", w + 1, 2'd0, 32'h18, 1'b1);
        drain();

        // EN=0 mid-count freezes COUNT
        wr(2'd1, 32'd100, dummy);
        wr(2'd0, 32'h11, e0);
        push("t6 run E1", e0 + 1, 2'd2, 32'd100, 1'b0);
        push("t6 run E5", e0 + 5, 2'd2, 32'd96, 1'b0);
        drain();
        wr(2'd0, 32'h00, w);
        push("t6 frozen W", w, 2'd2, 32'd96, 1'b0);
        push("t6 frozen W+5", w + 5, 2'd2, 32'd96, 1'b0);
        push("t6 frozen W+10", w + 10, 2'd2, 32'd96, 1'b0);
        push("t6 ctrl W+10", w + 10, 2'd0, 32'h00, 1'b0);
        drain();

        // Asynchronous reset while counting with irq asserted
        do_reset();
        wr(2'd1, 32'd5, dummy);
        wr(2'd3, 32'd0, dummy);
        wr(2'd0, 32'h0B, e0);
        push("t1 pre count", e0 + 9, 2'd2, 32'd4, 1'b1);
        push("t1 pre ctrl", e0 + 9, 2'd0, 32'h1B, 1'b1);
        drain();
        #1;
        rst = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) rd_chk("t1 in reset", 2'(a), 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push("t1 idle count", edge_cnt + 3, 2'd2, 32'd0, 1'b0);
        push("t1 idle ctrl", edge_cnt + 3, 2'd0, 32'h0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
